// File: rtl/incubator_pkg.sv
// ----------------------------------------------------------------------------
// incubator_pkg
//   Shared definitions for the incubator thermostat controller:
//   climate/cooler-speed state encodings, temperature thresholds and
//   fan speed codes, plus a helper that maps a cooler-speed state to its
//   fan speed code.
// ----------------------------------------------------------------------------
package incubator_pkg;

    // Temperature thresholds (unsigned degrees, all comparisons strict).
    localparam logic [7:0] T_HEAT_ON  = 8'd15;
    localparam logic [7:0] T_HEAT_OFF = 8'd30;
    localparam logic [7:0] T_COOL_ON  = 8'd35;
    localparam logic [7:0] T_COOL_OFF = 8'd25;
    localparam logic [7:0] T_SPD2_UP  = 8'd40;
    localparam logic [7:0] T_SPD3_UP  = 8'd45;
    localparam logic [7:0] T_SPD1_DN  = 8'd35;

    // Main climate states. Encoding 2'b11 is unused and recovers to idle.
    typedef logic [1:0] main_state_t;
    localparam main_state_t MAIN_S1 = 2'd0;  // idle
    localparam main_state_t MAIN_S2 = 2'd1;  // cooling
    localparam main_state_t MAIN_S3 = 2'd2;  // heating

    // Cooler-speed (CRS) states.
    typedef logic [1:0] crs_state_t;
    localparam crs_state_t CRS_OUT = 2'd0;
    localparam crs_state_t CRS_S1  = 2'd1;
    localparam crs_state_t CRS_S2  = 2'd2;
    localparam crs_state_t CRS_S3  = 2'd3;

    // Fan speed codes.
    localparam logic [3:0] SPD_OUT = 4'd0;
    localparam logic [3:0] SPD1    = 4'd4;
    localparam logic [3:0] SPD2    = 4'd6;
    localparam logic [3:0] SPD3    = 4'd8;

    function automatic logic [3:0] crs_speed(input crs_state_t s);
        case (s)
            CRS_S1:  crs_speed = SPD1;
            CRS_S2:  crs_speed = SPD2;
            CRS_S3:  crs_speed = SPD3;
            default: crs_speed = SPD_OUT;
        endcase
    endfunction

endpackage

// File: rtl/incubator_crs_fsm.sv
// ----------------------------------------------------------------------------
// incubator_crs_fsm
//   Nested cooler-speed FSM. Steps the fan speed up or down one level per
//   clock while cooling is active; parks in OUT whenever cooling is not.
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset (-> OUT)
//   cool_active  in   main FSM will be in cooling after this edge
//   temperature  in   8-bit unsigned sensor reading
//   crs_state    out  registered CRS state
//   speed        out  fan speed code decoded from crs_state
// ----------------------------------------------------------------------------
module incubator_crs_fsm
    import incubator_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cool_active,
    input  logic [7:0] temperature,
    output crs_state_t crs_state,
    output logic [3:0] speed
);

    crs_state_t crs_next;

    // cool_active is the main FSM's *next* state, so OUT->S1 lands on the
    // same edge as main idle->cooling, and S1->OUT on the same edge as
    // main cooling->idle (that exit is decided entirely by the main FSM).
    always_comb begin
        // NOTE: default assignment first so every path drives crs_next and no latch is inferred.
        crs_next = crs_state;
        if (!cool_active) begin
            crs_next = CRS_OUT;
        end else begin
            case (crs_state)
                CRS_OUT: crs_next = CRS_S1;
                CRS_S1:  if (temperature > T_SPD2_UP) crs_next = CRS_S2;
                CRS_S2: begin
                    if (temperature > T_SPD3_UP)      crs_next = CRS_S3;
                    else if (temperature < T_SPD1_DN) crs_next = CRS_S1;
                end
                CRS_S3:  if (temperature < T_SPD2_UP) crs_next = CRS_S2;
                default: crs_next = CRS_OUT;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk) begin
        if (reset) crs_state <= CRS_OUT;
        else       crs_state <= crs_next;
    end

    assign speed = crs_speed(crs_state);

endmodule

// File: rtl/incubator_controller.sv
// ----------------------------------------------------------------------------
// incubator_controller
//   Thermostat controller for a lab incubator: main climate FSM
//   (idle / cooling / heating) plus a nested cooler-speed FSM.
//   Outputs are Moore, decoded from registered state (one clock latency).
// Ports
//   clk                      in   system clock, rising edge
//   reset                    in   synchronous active-high reset
//   temperature              in   8-bit unsigned sensor reading
//   cooler_on                out  cooler enable
//   cooler_rotational_speed  out  4-bit fan speed code
//   heater_on                out  heater enable
// ----------------------------------------------------------------------------
module incubator_controller
    import incubator_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] temperature,
    output logic       cooler_on,
    output logic [3:0] cooler_rotational_speed,
    output logic       heater_on
);

    main_state_t main_state;
    main_state_t main_next;
    crs_state_t  crs_state;

    always_comb begin
        main_next = main_state;
        case (main_state)
            MAIN_S1: begin
                if (temperature < T_HEAT_ON)      main_next = MAIN_S3;
                else if (temperature > T_COOL_ON) main_next = MAIN_S2;
            end
            MAIN_S3: if (temperature > T_HEAT_OFF) main_next = MAIN_S1;
            // Cooling only ends once the fan has walked down to its lowest level.
            MAIN_S2: if (temperature < T_COOL_OFF && crs_state == CRS_S1) main_next = MAIN_S1;
            default: main_next = MAIN_S1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) main_state <= MAIN_S1;
        else       main_state <= main_next;
    end

    incubator_crs_fsm u_crs (
        .clk         (clk),
        .reset       (reset),
        .cool_active (main_next == MAIN_S2),
        .temperature (temperature),
        .crs_state   (crs_state),
        .speed       (cooler_rotational_speed)
    );

    assign heater_on = (main_state == MAIN_S3);
    assign cooler_on = (main_state == MAIN_S2);

endmodule

// File: tb/tb_incubator_controller.sv
// ----------------------------------------------------------------------------
// tb_incubator_controller
//   Directed scenarios with expected values taken from the thermostat rules,
//   followed by randomized temperatures checked against a behavioural model.
// ----------------------------------------------------------------------------
module tb_incubator_controller;

    logic       clk;
    logic       reset;
    logic [7:0] temperature;
    logic       cooler_on;
    logic [3:0] cooler_rotational_speed;
    logic       heater_on;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: climate mode and fan level (0 = fan off, 1..3).
    localparam int M_IDLE = 0, M_COOL = 1, M_HEAT = 2;
    int m_mode  = M_IDLE;
    int m_level = 0;

    typedef struct {
        logic [7:0] t;
        logic       r;
        logic       h;
        logic       c;
        logic [3:0] s;
    } row_t;

    incubator_controller dut (
        .clk                     (clk),
        .reset                   (reset),
        .temperature             (temperature),
        .cooler_on               (cooler_on),
        .cooler_rotational_speed (cooler_rotational_speed),
        .heater_on               (heater_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one sample, clock it in, advance the model from the same sample.
    task automatic tick(input logic [7:0] t, input logic r);
        int t_i;
        int old_level;
        temperature = t;
        reset       = r;
        @(posedge clk);
        #1;
        t_i       = int'(t);
        old_level = m_level;
        if (r) begin
            m_mode  = M_IDLE;
            m_level = 0;
        end else if (m_mode == M_IDLE) begin
            if (t_i < 15) m_mode = M_HEAT;
            else if (t_i > 35) begin
                m_mode  = M_COOL;
                m_level = 1;
            end
        end else if (m_mode == M_HEAT) begin
            if (t_i > 30) m_mode = M_IDLE;
        end else begin
            if (t_i < 25 && old_level == 1) begin
                m_mode  = M_IDLE;
                m_level = 0;
            end else if (old_level == 1 && t_i > 40) m_level = 2;
            else if (old_level == 2 && t_i > 45)     m_level = 3;
            else if (old_level == 2 && t_i < 35)     m_level = 1;
            else if (old_level == 3 && t_i < 40)     m_level = 2;
        end
    endtask

    task automatic test_reset;
        tick(8'd20, 1'b1);
        n_checks++;
        if (heater_on !== 1'b0) $display("FAIL reset heater_on: got %b expected 0", heater_on);
        else n_pass++;
        n_checks++;
        if (cooler_on !== 1'b0) $display("FAIL reset cooler_on: got %b expected 0", cooler_on);
        else n_pass++;
        n_checks++;
        if (cooler_rotational_speed !== 4'd0)
            $display("FAIL reset speed: got %0d expected 0", cooler_rotational_speed);
        else n_pass++;
    endtask

    task automatic test_heating;
        row_t rows [7];
        rows = '{'{8'd4,  1'b0, 1'b1, 1'b0, 4'd0},
                 '{8'd10, 1'b0, 1'b1, 1'b0, 4'd0},
                 '{8'd20, 1'b0, 1'b1, 1'b0, 4'd0},
                 '{8'd31, 1'b0, 1'b0, 1'b0, 4'd0},
                 '{8'd4,  1'b0, 1'b1, 1'b0, 4'd0},
                 '{8'd30, 1'b0, 1'b1, 1'b0, 4'd0},
                 '{8'd31, 1'b0, 1'b0, 1'b0, 4'd0}};
        foreach (rows[i]) begin
            tick(rows[i].t, rows[i].r);
            n_checks++;
            if (heater_on !== rows[i].h)
                $display("FAIL heating[%0d] heater_on: got %b expected %b", i, heater_on, rows[i].h);
            else n_pass++;
            n_checks++;
            if (cooler_on !== rows[i].c)
                $display("FAIL heating[%0d] cooler_on: got %b expected %b", i, cooler_on, rows[i].c);
            else n_pass++;
            n_checks++;
            if (cooler_rotational_speed !== rows[i].s)
                $display("FAIL heating[%0d] speed: got %0d expected %0d", i, cooler_rotational_speed, rows[i].s);
            else n_pass++;
        end
    endtask

    task automatic test_cooling;
        row_t rows [7];
        rows = '{'{8'd36, 1'b0, 1'b0, 1'b1, 4'd4},
                 '{8'd41, 1'b0, 1'b0, 1'b1, 4'd6},
                 '{8'd46, 1'b0, 1'b0, 1'b1, 4'd8},
                 '{8'd50, 1'b0, 1'b0, 1'b1, 4'd8},
                 '{8'd37, 1'b0, 1'b0, 1'b1, 4'd6},
                 '{8'd30, 1'b0, 1'b0, 1'b1, 4'd4},
                 '{8'd20, 1'b0, 1'b0, 1'b0, 4'd0}};
        foreach (rows[i]) begin
            tick(rows[i].t, rows[i].r);
            n_checks++;
            if (heater_on !== rows[i].h)
                $display("FAIL cooling[%0d] heater_on: got %b expected %b", i, heater_on, rows[i].h);
            else n_pass++;
            n_checks++;
            if (cooler_on !== rows[i].c)
                $display("FAIL cooling[%0d] cooler_on: got %b expected %b", i, cooler_on, rows[i].c);
            else n_pass++;
            n_checks++;
            if (cooler_rotational_speed !== rows[i].s)
                $display("FAIL cooling[%0d] speed: got %0d expected %0d", i, cooler_rotational_speed, rows[i].s);
            else n_pass++;
        end
    endtask

    task automatic test_step_drop;
        row_t rows [6];
        rows = '{'{8'd36, 1'b0, 1'b0, 1'b1, 4'd4},
                 '{8'd41, 1'b0, 1'b0, 1'b1, 4'd6},
                 '{8'd46, 1'b0, 1'b0, 1'b1, 4'd8},
                 '{8'd20, 1'b0, 1'b0, 1'b1, 4'd6},
                 '{8'd20, 1'b0, 1'b0, 1'b1, 4'd4},
                 '{8'd20, 1'b0, 1'b0, 1'b0, 4'd0}};
        foreach (rows[i]) begin
            tick(rows[i].t, rows[i].r);
            n_checks++;
            if (heater_on !== rows[i].h)
                $display("FAIL step_drop[%0d] heater_on: got %b expected %b", i, heater_on, rows[i].h);
            else n_pass++;
            n_checks++;
            if (cooler_on !== rows[i].c)
                $display("FAIL step_drop[%0d] cooler_on: got %b expected %b", i, cooler_on, rows[i].c);
            else n_pass++;
            n_checks++;
            if (cooler_rotational_speed !== rows[i].s)
                $display("FAIL step_drop[%0d] speed: got %0d expected %0d", i, cooler_rotational_speed, rows[i].s);
            else n_pass++;
        end
    endtask

    // Equality at each threshold must not move either FSM.
    task automatic test_boundaries;
        row_t rows [8];
        rows = '{'{8'd15, 1'b0, 1'b0, 1'b0, 4'd0},
                 '{8'd35, 1'b0, 1'b0, 1'b0, 4'd0},
                 '{8'd36, 1'b0, 1'b0, 1'b1, 4'd4},
                 '{8'd40, 1'b0, 1'b0, 1'b1, 4'd4},
                 '{8'd25, 1'b0, 1'b0, 1'b1, 4'd4},
                 '{8'd41, 1'b0, 1'b0, 1'b1, 4'd6},
                 '{8'd45, 1'b0, 1'b0, 1'b1, 4'd6},
                 '{8'd35, 1'b0, 1'b0, 1'b1, 4'd6}};
        foreach (rows[i]) begin
            tick(rows[i].t, rows[i].r);
            n_checks++;
            if (heater_on !== rows[i].h)
                $display("FAIL boundary[%0d] heater_on: got %b expected %b", i, heater_on, rows[i].h);
            else n_pass++;
            n_checks++;
            if (cooler_on !== rows[i].c)
                $display("FAIL boundary[%0d] cooler_on: got %b expected %b", i, cooler_on, rows[i].c);
            else n_pass++;
            n_checks++;
            if (cooler_rotational_speed !== rows[i].s)
                $display("FAIL boundary[%0d] speed: got %0d expected %0d", i, cooler_rotational_speed, rows[i].s);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        row_t rows [5];
        rows = '{'{8'd41, 1'b0, 1'b0, 1'b1, 4'd6},
                 '{8'd46, 1'b0, 1'b0, 1'b1, 4'd8},
                 '{8'd50, 1'b1, 1'b0, 1'b0, 4'd0},
                 '{8'd50, 1'b0, 1'b0, 1'b1, 4'd4},
                 '{8'd5,  1'b1, 1'b0, 1'b0, 4'd0}};
        foreach (rows[i]) begin
            tick(rows[i].t, rows[i].r);
            n_checks++;
            if (heater_on !== rows[i].h)
                $display("FAIL reset_mid[%0d] heater_on: got %b expected %b", i, heater_on, rows[i].h);
            else n_pass++;
            n_checks++;
            if (cooler_on !== rows[i].c)
                $display("FAIL reset_mid[%0d] cooler_on: got %b expected %b", i, cooler_on, rows[i].c);
            else n_pass++;
            n_checks++;
            if (cooler_rotational_speed !== rows[i].s)
                $display("FAIL reset_mid[%0d] speed: got %0d expected %0d", i, cooler_rotational_speed, rows[i].s);
            else n_pass++;
        end
    endtask

    task automatic test_random;
        logic [7:0] t;
        logic       r;
        logic [3:0] exp_speed;
        for (int i = 0; i < 2000; i++) begin
            // Mostly the interesting 0..60 band, occasionally the full range.
            if ($urandom_range(0, 15) == 0) t = 8'($urandom_range(0, 255));
            else                            t = 8'($urandom_range(0, 60));
            r = ($urandom_range(0, 99) == 0);
            tick(t, r);
            exp_speed = (m_level == 0) ? 4'd0 : 4'(2 + 2 * m_level);
            n_checks++;
            if (heater_on !== (m_mode == M_HEAT))
                $display("FAIL random[%0d] heater_on: got %b expected %b (temp %0d)",
                         i, heater_on, (m_mode == M_HEAT), t);
            else n_pass++;
            n_checks++;
            if (cooler_on !== (m_mode == M_COOL))
                $display("FAIL random[%0d] cooler_on: got %b expected %b (temp %0d)",
                         i, cooler_on, (m_mode == M_COOL), t);
            else n_pass++;
            n_checks++;
            if (cooler_rotational_speed !== exp_speed)
                $display("FAIL random[%0d] speed: got %0d expected %0d (temp %0d)",
                         i, cooler_rotational_speed, exp_speed, t);
            else n_pass++;
        end
    endtask

    initial begin
        reset       = 1'b1;
        temperature = 8'd20;
        test_reset();
        test_heating();
        test_cooling();
        test_step_drop();
        test_boundaries();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
